// File: rtl/adsr_pkg.sv
// Shared ADSR state encoding, level ceiling and default widths.
// Pure definitions, no logic; no flow control.
package adsr_pkg;

    localparam int LVL_W_DEF  = 7;
    localparam int TIME_W_DEF = 7;
    localparam int LVL_MAX    = 127;

    typedef enum logic [2:0] {
        ADSR_IDLE    = 3'd0,
        ADSR_ATTACK  = 3'd1,
        ADSR_DECAY   = 3'd2,
        ADSR_SUSTAIN = 3'd3,
        ADSR_RELEASE = 3'd4
    } adsr_state_t;

endpackage

// File: rtl/adsr_lvl_scale.sv
// P(x,s) = (x*s) >> W with truncation, computed on a 2W-bit product.
// Purely combinational, zero latency; no flow control.
module adsr_lvl_scale #(
    parameter int W = 7
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_s,
    output logic [W-1:0] o_p
);

    assign o_p = W'(({{W{1'b0}}, i_x} * {{W{1'b0}}, i_s}) >> W);

endmodule

// File: rtl/adsr_env_fsm.sv
// ADSR envelope sequencer; ADSR_SOFT_RETRIG_EN makes a retrigger ramp from the current level.
// Latency env_dv -> env_level_dv is 1 clk; no backpressure, one level per NCO strobe.
module adsr_env_fsm
    import adsr_pkg::*;
#(
    parameter int LVL_W  = LVL_W_DEF,
    parameter int TIME_W = TIME_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_gate,
    input  logic [TIME_W-1:0] i_attack,
    input  logic [TIME_W-1:0] i_decay,
    input  logic [LVL_W-1:0]  i_sustain,
    input  logic [TIME_W-1:0] i_release,
    input  logic [LVL_W-1:0]  i_env_scale,
    input  logic              i_env_ovflow,
    input  logic              i_env_dv,
    output logic [TIME_W-1:0] o_env_time,
    output logic              o_nco_clr,
    output logic [LVL_W-1:0]  o_env_level,
    output logic              o_env_level_dv,
    output logic              o_active
);

    localparam logic [2:0] S_IDLE    = ADSR_IDLE;
    localparam logic [2:0] S_ATTACK  = ADSR_ATTACK;
    localparam logic [2:0] S_DECAY   = ADSR_DECAY;
    localparam logic [2:0] S_SUSTAIN = ADSR_SUSTAIN;
    localparam logic [2:0] S_RELEASE = ADSR_RELEASE;

    localparam logic [LVL_W-1:0] LVL_TOP = LVL_W'(LVL_MAX);

    logic [2:0]       r_state;
    logic             r_gate_q;
    logic [LVL_W-1:0] r_start_lvl;
    logic [LVL_W-1:0] r_env_level;
    logic             r_env_level_dv;
    logic             r_nco_clr;

    logic [2:0]       w_state_nxt;
    logic             w_rise;
    logic             w_fall_act;
    logic             w_gate_evt;
    logic             w_wrap;
    logic             w_wrap_eff;
    logic [LVL_W-1:0] w_rise_start;
    logic [LVL_W-1:0] w_x_up;
    logic [LVL_W-1:0] w_p_up;
    logic [LVL_W-1:0] w_p_dn;
    logic [LVL_W-1:0] w_attack_lvl;
    logic [LVL_W-1:0] w_decay_lvl;
    logic [LVL_W-1:0] w_release_lvl;
    logic [LVL_W-1:0] w_lvl_nxt;

    assign w_rise     = i_gate & ~r_gate_q;
    assign w_fall_act = ~i_gate & r_gate_q &
                        ((r_state == S_ATTACK) | (r_state == S_DECAY) | (r_state == S_SUSTAIN));
    assign w_gate_evt = w_rise | w_fall_act;
    assign w_wrap     = i_env_dv & i_env_ovflow;
    // A gate event in the same cycle as a wrap wins, so the wrap endpoint is not applied.
    assign w_wrap_eff = w_wrap & ~w_gate_evt;

`ifdef ADSR_SOFT_RETRIG_EN
    assign w_rise_start = (r_state == S_IDLE) ? '0 : r_env_level;
`else
    assign w_rise_start = '0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        if (w_rise) begin
            w_state_nxt = S_ATTACK;
        end else if (w_fall_act) begin
            w_state_nxt = S_RELEASE;
        end else if (w_wrap) begin
            case (r_state)
                S_ATTACK:  w_state_nxt = S_DECAY;
                S_DECAY:   w_state_nxt = S_SUSTAIN;
                S_RELEASE: w_state_nxt = S_IDLE;
                default:   w_state_nxt = r_state;
            endcase
        end
    end

    // Attack and decay both scale a distance-to-ceiling, so they share one multiplier.
    assign w_x_up = (r_state == S_DECAY) ? (LVL_TOP - i_sustain) : (LVL_TOP - r_start_lvl);

    adsr_lvl_scale #(.W(LVL_W)) u_scale_up (
        .i_x (w_x_up),
        .i_s (i_env_scale),
        .o_p (w_p_up)
    );

    adsr_lvl_scale #(.W(LVL_W)) u_scale_dn (
        .i_x (r_start_lvl),
        .i_s (i_env_scale),
        .o_p (w_p_dn)
    );

    assign w_attack_lvl  = LVL_W'({1'b0, r_start_lvl} + {1'b0, w_p_up});
    assign w_decay_lvl   = LVL_W'({1'b0, LVL_TOP} - {1'b0, w_p_up});
    assign w_release_lvl = LVL_W'({1'b0, r_start_lvl} - {1'b0, w_p_dn});

    always_comb begin
        w_lvl_nxt = '0;
        case (r_state)
            S_ATTACK:  w_lvl_nxt = w_wrap_eff ? LVL_TOP   : w_attack_lvl;
            S_DECAY:   w_lvl_nxt = w_wrap_eff ? i_sustain : w_decay_lvl;
            S_SUSTAIN: w_lvl_nxt = i_sustain;
            S_RELEASE: w_lvl_nxt = w_wrap_eff ? '0        : w_release_lvl;
            default:   w_lvl_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_gate_q       <= 1'b0;
            r_start_lvl    <= '0;
            r_env_level    <= '0;
            r_env_level_dv <= 1'b0;
            r_nco_clr      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_gate_q       <= i_gate;
            r_env_level_dv <= i_env_dv;
            r_nco_clr      <= w_gate_evt;
            if (w_rise) begin
                r_start_lvl <= w_rise_start;
            end else if (w_fall_act) begin
                r_start_lvl <= r_env_level;
            end
            if (i_env_dv) begin
                r_env_level <= w_lvl_nxt;
            end
        end
    end

    always_comb begin
        o_env_time = '0;
        case (r_state)
            S_ATTACK:  o_env_time = i_attack;
            S_DECAY:   o_env_time = i_decay;
            S_RELEASE: o_env_time = i_release;
            default:   o_env_time = '0;
        endcase
    end

    assign o_nco_clr      = r_nco_clr;
    assign o_env_level    = r_env_level;
    assign o_env_level_dv = r_env_level_dv;
    assign o_active       = (r_state != S_IDLE);

endmodule
